// File: rtl/spi_blinky_pkg.sv
// Shared types and constants for the SPI command decoder and its blink timer.
package spi_blinky_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_DATA  = 2'd1,
        ST_RD_DUMMY = 2'd2,
        ST_ERR      = 2'd3
    } state_t;

    localparam logic [2:0] ADDR_LED_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_BLINK_MASK = 3'd1;
    localparam logic [2:0] ADDR_BLINK_DIV  = 3'd2;
    localparam logic [2:0] ADDR_STATUS     = 3'd3;
    localparam logic [2:0] ADDR_ID         = 3'd4;

    localparam logic [7:0] ID_DEFAULT = 8'hA5;

    // A command is legal when its reserved bits are clear, it targets a mapped
    // address, and it does not try to write the read-only ID register.
    function automatic logic cmd_is_valid(input logic [7:0] cmd);
        logic [2:0] addr;
        addr = cmd[2:0];
        return (cmd[6:3] == 4'h0) && (addr <= ADDR_ID) &&
               !(cmd[7] && (addr == ADDR_ID));
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Free-running prescaler feeding a tick counter that toggles the blink phase
// every BLINK_DIV ticks. A divider of zero parks the phase low.
module blink_timer #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic       i_clk,
    input  logic       i_sys_rst,
    input  logic [7:0] i_div,
    input  logic       i_div_wr,
    output logic       o_phase
);

    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic                  tick;

    // Next-state: prescaler always runs; counter/phase restart on divider writes.
    always_comb begin
        pre_d   = pre_q + 1'b1;
        tick    = &pre_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if ((i_div == 8'd0) || i_div_wr) begin
            cnt_d   = 8'd0;
            phase_d = 1'b0;
        end else if (tick) begin
            if (cnt_q == (i_div - 8'd1)) begin
                cnt_d   = 8'd0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Timer registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_sys_rst) begin
            pre_q   <= '0;
            cnt_q   <= 8'd0;
            phase_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign o_phase = phase_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Byte-level command decoder sitting behind an SPI slave: parses read/write
// frames into a small register file and drives a blinking LED output.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | next byte is a command
// ST_WR_DATA  | next byte is write data for the latched address
// ST_RD_DUMMY | read response issued; next byte is a dummy and is dropped
// ST_ERR      | bad command seen; drop bytes until chip select rises
module spi_cmd_decoder
    import spi_blinky_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 16,
    parameter logic [7:0]  ID_VALUE   = ID_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_sys_rst,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_rdy,
    input  logic       i_cs,
    output logic [7:0] o_tx_byte,
    output logic       o_tx_rdy,
    output logic [4:0] o_led,
    output logic       o_err
);

    state_t     state_q, state_d;
    logic [2:0] addr_q, addr_d;
    logic [4:0] led_ctrl_q, led_ctrl_d;
    logic [4:0] blink_mask_q, blink_mask_d;
    logic [7:0] blink_div_q, blink_div_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       tx_rdy_q, tx_rdy_d;
    logic [4:0] led_q, led_d;
    logic       cs_meta_q, cs_sync_q, cs_prev_q;
    logic       frame_end;
    logic       div_wr;
    logic       phase;
    logic [7:0] rd_val;
    logic [7:0] status_val;

    assign frame_end  = cs_sync_q & ~cs_prev_q;
    assign status_val = {err_cnt_q, 4'h0};

    // Register read mux, addressed directly by the incoming command byte.
    always_comb begin
        rd_val = 8'h00;
        case (i_rx_byte[2:0])
            ADDR_LED_CTRL:   rd_val = {3'b000, led_ctrl_q};
            ADDR_BLINK_MASK: rd_val = {3'b000, blink_mask_q};
            ADDR_BLINK_DIV:  rd_val = blink_div_q;
            ADDR_STATUS:     rd_val = status_val;
            ADDR_ID:         rd_val = ID_VALUE;
            default:         rd_val = 8'h00;
        endcase
    end

    // Frame FSM, register writes and read-response generation.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        led_ctrl_d   = led_ctrl_q;
        blink_mask_d = blink_mask_q;
        blink_div_d  = blink_div_q;
        err_cnt_d    = err_cnt_q;
        div_wr       = 1'b0;
        tx_byte_d    = status_val;
        tx_rdy_d     = 1'b0;
        if (frame_end) begin
            // End of frame beats a coincident byte: it is simply dropped.
            state_d = ST_IDLE;
        end else if (i_rx_rdy) begin
            case (state_q)
                ST_IDLE: begin
                    if (!cmd_is_valid(i_rx_byte)) begin
                        state_d = ST_ERR;
                        if (err_cnt_q != 4'hF) begin
                            err_cnt_d = err_cnt_q + 4'd1;
                        end
                    end else if (i_rx_byte[7]) begin
                        state_d = ST_WR_DATA;
                        addr_d  = i_rx_byte[2:0];
                    end else begin
                        state_d   = ST_RD_DUMMY;
                        tx_byte_d = rd_val;
                        tx_rdy_d  = 1'b1;
                    end
                end
                ST_WR_DATA: begin
                    state_d = ST_IDLE;
                    case (addr_q)
                        ADDR_LED_CTRL:   led_ctrl_d   = i_rx_byte[4:0];
                        ADDR_BLINK_MASK: blink_mask_d = i_rx_byte[4:0];
                        ADDR_BLINK_DIV: begin
                            blink_div_d = i_rx_byte;
                            div_wr      = 1'b1;
                        end
                        ADDR_STATUS:     err_cnt_d    = 4'h0;
                        default:         ;
                    endcase
                end
                ST_RD_DUMMY: state_d = ST_IDLE;
                ST_ERR:      state_d = ST_ERR;
                default:     state_d = ST_IDLE;
            endcase
        end
        led_d = led_ctrl_q ^ (blink_mask_q & {5{phase}});
    end

    // All decoder flops, including the three-stage chip-select synchroniser/edge detector.
    always_ff @(posedge i_clk) begin
        if (!i_sys_rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= 3'd0;
            led_ctrl_q   <= 5'd0;
            blink_mask_q <= 5'd0;
            blink_div_q  <= 8'd0;
            err_cnt_q    <= 4'd0;
            tx_byte_q    <= 8'h00;
            tx_rdy_q     <= 1'b0;
            led_q        <= 5'd0;
            cs_meta_q    <= 1'b1;
            cs_sync_q    <= 1'b1;
            cs_prev_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            led_ctrl_q   <= led_ctrl_d;
            blink_mask_q <= blink_mask_d;
            blink_div_q  <= blink_div_d;
            err_cnt_q    <= err_cnt_d;
            tx_byte_q    <= tx_byte_d;
            tx_rdy_q     <= tx_rdy_d;
            led_q        <= led_d;
            cs_meta_q    <= i_cs;
            cs_sync_q    <= cs_meta_q;
            cs_prev_q    <= cs_sync_q;
        end
    end

    blink_timer #(
        .PRESCALE_W (PRESCALE_W)
    ) u_blink_timer (
        .i_clk     (i_clk),
        .i_sys_rst (i_sys_rst),
        .i_div     (blink_div_q),
        .i_div_wr  (div_wr),
        .o_phase   (phase)
    );

    assign o_tx_byte = tx_byte_q;
    assign o_tx_rdy  = tx_rdy_q;
    assign o_led     = led_q;
    assign o_err     = (state_q == ST_ERR);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench: frames are parsed by a list-level model of the
// register map; a monitor checks read responses and idle outputs every cycle.
module tb_spi_cmd_decoder;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_rdy;
    logic       cs;
    logic [7:0] tx_byte;
    logic       tx_rdy;
    logic [4:0] led;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic [4:0] m_led = 5'd0;
    logic [4:0] m_mask = 5'd0;
    logic [7:0] m_div = 8'd0;
    int         m_err = 0;
    logic [7:0] exp_q[$];
    bit         settled = 1'b0;

    spi_cmd_decoder #(.PRESCALE_W(4), .ID_VALUE(8'hA5)) dut (
        .i_clk     (clk),
        .i_sys_rst (rst_n),
        .i_rx_byte (rx_byte),
        .i_rx_rdy  (rx_rdy),
        .i_cs      (cs),
        .o_tx_byte (tx_byte),
        .o_tx_rdy  (tx_rdy),
        .o_led     (led),
        .o_err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] reg_read(input logic [2:0] a);
        case (a)
            3'd0:    return {3'b000, m_led};
            3'd1:    return {3'b000, m_mask};
            3'd2:    return m_div;
            3'd3:    return {4'(m_err), 4'h0};
            default: return 8'hA5;
        endcase
    endfunction

    // Walks the byte list of a frame: command, then its data/dummy byte.
    task automatic model_frame(input bq_t fb, output bit ends_in_err);
        int         i;
        logic [7:0] c;
        logic [2:0] a;
        bit         bad;
        i = 0;
        ends_in_err = 1'b0;
        while (i < fb.size()) begin
            c   = fb[i];
            a   = c[2:0];
            bad = (c[6:3] != 4'h0) || (a > 3'd4) || (c[7] && a == 3'd4);
            if (bad) begin
                if (m_err < 15) m_err++;
                ends_in_err = 1'b1;
                break;
            end
            if (c[7]) begin
                if (i + 1 < fb.size()) begin
                    case (a)
                        3'd0: m_led  = fb[i+1][4:0];
                        3'd1: m_mask = fb[i+1][4:0];
                        3'd2: m_div  = fb[i+1];
                        3'd3: m_err  = 0;
                        default: ;
                    endcase
                end
            end else begin
                exp_q.push_back(reg_read(a));
            end
            i += 2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_rdy  = 1'b1;
        step();
        rx_rdy  = 1'b0;
        step();
        step();
    endtask

    task automatic cs_high();
        cs = 1'b1;
        repeat (5) step();
    endtask

    task automatic send_frame(input bq_t fb, input bit settle_after);
        bit in_err;
        settled = 1'b0;
        model_frame(fb, in_err);
        cs = 1'b0;
        repeat (3) step();
        foreach (fb[i]) send_byte(fb[i]);
        check("err_flag", int'(err), int'(in_err));
        cs_high();
        settled = settle_after;
    endtask

    task automatic random_frame();
        bq_t        fb;
        int         ncmd;
        int         kind;
        logic [2:0] a;
        logic [7:0] d;
        ncmd = $urandom_range(1, 2);
        for (int k = 0; k < ncmd; k++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                a = 3'($urandom_range(0, 4));
                fb.push_back({5'b00000, a});
                fb.push_back(8'($urandom));
            end else if (kind <= 2) begin
                a = 3'($urandom_range(0, 3));
                d = (a == 3'd2) ? 8'h00 : 8'($urandom);
                fb.push_back({5'b10000, a});
                fb.push_back(d);
            end else begin
                case ($urandom_range(0, 2))
                    0: fb.push_back({1'($urandom), 4'($urandom_range(1, 15)), 3'($urandom)});
                    1: fb.push_back({1'($urandom), 4'h0, 3'($urandom_range(5, 7))});
                    default: fb.push_back(8'h84);
                endcase
                repeat ($urandom_range(0, 2)) fb.push_back(8'($urandom));
                break;
            end
        end
        if (fb.size() > 1 && $urandom_range(0, 5) == 0) void'(fb.pop_back());
        send_frame(fb, 1'b1);
    endtask

    // Monitor: every read pulse against the model queue; idle outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_rdy) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_tx_rdy: got tx_byte 0x%0h, expected no pulse", tx_byte);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_byte != e) begin
                        n_errors++;
                        $display("FAIL read_data: got 0x%0h, expected 0x%0h", tx_byte, e);
                    end
                end
            end
            if (settled) begin
                check("idle_led", int'(led), int'(m_led));
                check("idle_status", int'(tx_byte), int'({4'(m_err), 4'h0}));
                check("idle_err", int'(err), 0);
                check("idle_tx_rdy", int'(tx_rdy), 0);
            end
        end
    end

    initial begin
        logic [4:0] v;
        int         cnt;
        bit         found;

        rst_n = 1'b0; cs = 1'b1; rx_rdy = 1'b0; rx_byte = 8'h00;
        repeat (3) step();
        check("rst_led", int'(led), 0);
        check("rst_tx_byte", int'(tx_byte), 0);
        check("rst_tx_rdy", int'(tx_rdy), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;
        repeat (3) step();
        settled = 1'b1;

        // LED write and its two-cycle visibility
        settled = 1'b0;
        cs = 1'b0; repeat (3) step();
        send_byte(8'h80);
        rx_byte = 8'h15; rx_rdy = 1'b1;
        step();
        rx_rdy = 1'b0;
        check("led_lat1", int'(led), 0);
        step();
        check("led_lat2", int'(led), 8'h15);
        m_led = 5'h15;
        cs_high();
        settled = 1'b1;

        // ID read: pulse one cycle after rdy, dummy byte ignored, then a read of LED_CTRL
        settled = 1'b0;
        cs = 1'b0; repeat (3) step();
        exp_q.push_back(8'hA5);
        rx_byte = 8'h04; rx_rdy = 1'b1;
        step();
        rx_rdy = 1'b0;
        check("id_tx_rdy", int'(tx_rdy), 1);
        check("id_tx_byte", int'(tx_byte), 8'hA5);
        step();
        check("id_pulse_width", int'(tx_rdy), 0);
        send_byte(8'h80);
        exp_q.push_back(8'h15);
        send_byte(8'h00);
        check("after_dummy_led", int'(led), 8'h15);
        cs_high();
        settled = 1'b1;

        // error frames saturate the counter, then a STATUS write clears it
        for (int n = 0; n < 17; n++) send_frame('{8'h47, 8'h80, 8'h1F}, 1'b1);
        check("status_saturated", int'(tx_byte), 8'hF0);
        check("led_untouched", int'(led), 8'h15);
        send_frame('{8'h03, 8'h00}, 1'b1);
        send_frame('{8'h83, 8'h00}, 1'b1);
        check("status_cleared", int'(tx_byte), 8'h00);

        // aborted write and a data byte coincident with frame_end
        send_frame('{8'h81, 8'h0A}, 1'b1);
        send_frame('{8'h81}, 1'b1);
        settled = 1'b0;
        cs = 1'b0; repeat (3) step();
        send_byte(8'h81);
        cs = 1'b1;
        step();
        step();
        rx_byte = 8'h1F; rx_rdy = 1'b1;
        step();
        rx_rdy = 1'b0;
        repeat (4) step();
        settled = 1'b1;
        send_frame('{8'h01, 8'h00}, 1'b1);
        check("mask_after_abort", int'(reg_read(3'd1)), 8'h0A);
        check("status_after_coincident", int'(tx_byte), 8'h00);

        // blink: 32-clock half period with PRESCALE_W=4, DIV=2
        send_frame('{8'h80, 8'h00}, 1'b0);
        send_frame('{8'h81, 8'h1F}, 1'b0);
        send_frame('{8'h82, 8'h02}, 1'b0);
        found = 1'b0;
        for (int t = 0; t < 64 && !found; t++) begin
            if (led != 5'h00) found = 1'b1;
            else step();
        end
        check("blink_first_toggle", int'(led), 8'h1F);
        for (int t = 0; t < 4; t++) begin
            v = led;
            cnt = 0;
            do begin
                step();
                cnt++;
            end while (led == v && cnt < 40);
            check("blink_period", cnt, 32);
            check("blink_level", int'(led), (v == 5'h00) ? 8'h1F : 8'h00);
        end
        send_frame('{8'h82, 8'h00}, 1'b1);
        repeat (100) step();
        check("blink_disabled", int'(led), 0);

        // reset in the middle of a write
        send_frame('{8'h80, 8'h0C}, 1'b1);
        send_frame('{8'h47}, 1'b1);
        settled = 1'b0;
        cs = 1'b0; repeat (3) step();
        send_byte(8'h81);
        rst_n = 1'b0;
        step();
        step();
        check("midrst_led", int'(led), 0);
        check("midrst_tx_byte", int'(tx_byte), 0);
        check("midrst_tx_rdy", int'(tx_rdy), 0);
        check("midrst_err", int'(err), 0);
        m_led = 5'd0; m_mask = 5'd0; m_div = 8'd0; m_err = 0;
        rst_n = 1'b1;
        step();
        cs_high();
        send_frame('{8'h80, 8'h01}, 1'b1);
        check("post_rst_led", int'(led), 8'h01);

        // randomized frames against the model
        for (int n = 0; n < 60; n++) random_frame();
        repeat (5) step();
        settled = 1'b0;
        check("read_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 Parameter PRESCALE_W, default 16: width of the blink prescaler; one tick every 2^PRESCALE_W clocks.
REQ-002 Parameter ID_VALUE, default 8'hA5: constant returned by the ID register.
REQ-003 Port i_clk, input, 1: system clock; the only clock.
REQ-004 Port i_sys_rst, input, 1: reset, synchronous, active-low.
REQ-005 Port i_rx_byte, input, 8: received byte from the upstream SPI slave; valid when i_rx_rdy=1.
REQ-006 Port i_rx_rdy, input, 1: one-cycle pulse per received byte.
REQ-007 Port i_cs, input, 1: raw SPI chip select, active-low, asynchronous to i_clk.
REQ-008 Port o_tx_byte, output, 8: next byte for the SPI slave to shift out.
REQ-009 Port o_tx_rdy, output, 1: one-cycle pulse; o_tx_byte is valid and shall be latched by the slave.
REQ-010 Port o_led, output, 5: LED drive.
REQ-011 Port o_err, output, 1: high while the current frame is in the error state.

Function
REQ-012 Frame format: byte0 = command; bit7 = W (1 = write, 0 = read); bits6:3 shall be 0; bits2:0 = address. Write frames carry one data byte; read frames carry one dummy byte.
REQ-013 Register map: 0 LED_CTRL[4:0] RW; 1 BLINK_MASK[4:0] RW; 2 BLINK_DIV[7:0] RW; 3 STATUS RO, with [7:4] = err_cnt and [3:0] = 0, where a write of any data clears err_cnt; 4 ID RO = ID_VALUE; 5-7 invalid. Unused bits read 0.
REQ-014 i_cs shall be synchronised through two flops; frame_end = one-cycle pulse on the synchronised 0->1 edge.
REQ-015 FSM states: IDLE, WR_DATA, RD_DUMMY, ERR.
REQ-016 IDLE + rx_rdy with a valid write command -> WR_DATA; latch the address.
REQ-017 IDLE + rx_rdy with a valid read command -> RD_DUMMY; load the register value into o_tx_byte and pulse o_tx_rdy in the next cycle (latency 1).
REQ-018 IDLE + rx_rdy with reserved bits nonzero, an invalid address, or a write to address 4 -> ERR; err_cnt increments, saturating at 15.
REQ-019 WR_DATA + rx_rdy -> write the register in the next cycle; go to IDLE.
REQ-020 RD_DUMMY + rx_rdy -> discard the byte; go to IDLE. Back-to-back commands within one frame are therefore permitted.
REQ-021 ERR: discard all bytes until frame_end.
REQ-022 frame_end in any state -> IDLE next cycle. An aborted WR_DATA performs no write.
REQ-023 rx_rdy and frame_end in the same cycle: frame_end wins; the byte is discarded and no state or register effect occurs.
REQ-024 Outside a read response, o_tx_byte shall hold STATUS; its value shall update without asserting o_tx_rdy.
REQ-025 o_err = 1 exactly while the FSM is in ERR.
REQ-026 Blink: a prescaler of PRESCALE_W bits wraps and emits a tick. An 8-bit counter counts ticks; when the counter equals BLINK_DIV-1 it clears and blink phase toggles.
REQ-027 BLINK_DIV = 0 disables blinking: phase is held at 0 and the counter is held at 0.
REQ-028 Writing BLINK_DIV shall clear the tick counter and phase. The prescaler is not cleared.
REQ-029 o_led = LED_CTRL XOR (BLINK_MASK AND {5{phase}}); registered, 1-cycle latency after a register write.

Reset
REQ-030 On i_sys_rst = 0 at a clock edge, the following shall clear: FSM -> IDLE; LED_CTRL, BLINK_MASK, BLINK_DIV, err_cnt, prescaler, tick counter and phase = 0.
REQ-031 On reset, outputs shall be o_led = 0, o_tx_byte = 8'h00, o_tx_rdy = 0, o_err = 0. Both cs synchroniser flops reset to 1.
REQ-032 Reset mid-frame discards all partial command state. After release, the first byte of any frame is treated as a command only after a frame_end or a reset.

Structure
REQ-033 Package spi_blinky_pkg shall hold the FSM state enum, the register address constants (ADDR_LED_CTRL to ADDR_ID) and the default ID value.
REQ-034 Sub-module blink_timer shall hold the prescaler, tick counter and phase; its inputs are BLINK_DIV and a div_wr pulse, and its output is phase.

Verification
REQ-035 Write LED_CTRL: frame 8'h80, 8'h15 then cs high -> o_led = 5'h15 two cycles after the data rdy pulse.
REQ-036 Read ID: frame 8'h04 -> o_tx_rdy pulse with o_tx_byte = 8'hA5 one cycle after rdy; dummy byte ignored; FSM back in IDLE.
REQ-037 Errors: command 8'h47 -> o_err = 1 and remaining bytes ignored. After 17 such frames STATUS reads 8'hF0; writing 8'h83 then 8'h00 clears it to 8'h00.
REQ-038 Abort: 8'h81 then cs high before the data byte -> BLINK_MASK unchanged. Also cover rx_rdy coincident with frame_end -> no effect.
REQ-039 Blink: PRESCALE_W = 4, BLINK_DIV = 2, BLINK_MASK = 5'h1F, LED_CTRL = 0 -> o_led toggles between 5'h00 and 5'h1F every 32 clocks. Writing BLINK_DIV = 0 then holds o_led at 5'h00.
REQ-040 Reset asserted while in WR_DATA -> all outputs 0. The next frame 8'h80, 8'h01 sets o_led = 5'h01.
